// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the NPC load/store path.
// Sizes, FSM state encodings and the data width.
package npc_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2,
    LSU_D = 2'd3
  } lsu_size_e;

  typedef logic [1:0] lsu_state_e;

  localparam lsu_state_e IDLE   = 2'd0;
  localparam lsu_state_e ACCESS = 2'd1;
  localparam lsu_state_e RESP   = 2'd2;

endpackage

// File: rtl/npc_lsu_align.sv
// lsu_align: misalign detect, store lane shift and load extract/extend.
// Purely combinational; shared by the request check and the access cycle.
module lsu_align
  import npc_pkg::*;
(
  input  lsu_size_e             chk_size,
  input  logic [2:0]            chk_off,
  output logic                  misaligned,
  input  lsu_size_e             size,
  input  logic [2:0]            off,
  input  logic                  is_unsigned,
  input  logic [XLEN-1:0]       wdata,
  input  logic [XLEN-1:0]       rdata,
  output logic [XLEN/8-1:0]     wmask,
  output logic [XLEN-1:0]       wdata_sh,
  output logic [XLEN-1:0]       rdata_ext
);

  logic [XLEN/8-1:0] base_mask;
  logic [XLEN-1:0]   sh;
  logic [5:0]        bit_off;

  assign bit_off = {off, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    unique case (chk_size)
      LSU_B: misaligned = 1'b0;
      LSU_H: misaligned = chk_off[0];
      LSU_W: misaligned = |chk_off[1:0];
      LSU_D: misaligned = |chk_off;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    base_mask = 8'h00;
    unique case (size)
      LSU_B: base_mask = 8'h01;
      LSU_H: base_mask = 8'h03;
      LSU_W: base_mask = 8'h0F;
      LSU_D: base_mask = 8'hFF;
      default: base_mask = 8'h00;
    endcase
  end

  assign wmask    = base_mask << off;
  assign wdata_sh = wdata << bit_off;
  assign sh       = rdata >> bit_off;

  always_comb begin
    rdata_ext = '0;
    unique case (size)
      LSU_B: rdata_ext = is_unsigned ? {56'd0, sh[7:0]}
                                     : {{56{sh[7]}}, sh[7:0]};
      LSU_H: rdata_ext = is_unsigned ? {48'd0, sh[15:0]}
                                     : {{48{sh[15]}}, sh[15:0]};
      LSU_W: rdata_ext = is_unsigned ? {32'd0, sh[31:0]}
                                     : {{32{sh[31]}}, sh[31:0]};
      LSU_D: rdata_ext = sh;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/npc_lsu.sv
// npc_lsu: load/store unit between EXU and the data-memory port.
// One request per handshake, one-cycle memory strobe, registered response.
module npc_lsu #(
  parameter int XLEN   = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [XLEN-1:0]   mem_raddr,
  output logic              mem_read,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   mem_waddr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  output logic              mem_write
);

  import npc_pkg::*;

  lsu_state_e      state_q;
  logic            wen_q;
  lsu_size_e       size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;

  logic              accept;
  logic              misaligned;
  logic [MASK_W-1:0] wmask;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   rdata_ext;
  logic [XLEN-1:0]   line_addr;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;

  lsu_align u_align (
    .chk_size    (lsu_size_e'(req_size)),
    .chk_off     (req_addr[2:0]),
    .misaligned  (misaligned),
    .size        (size_q),
    .off         (addr_q[2:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .wmask       (wmask),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext)
  );

  assign line_addr = {addr_q[XLEN-1:3], 3'b000};
  assign mem_read  = (state_q == ACCESS) && !wen_q;
  assign mem_write = (state_q == ACCESS) && wen_q;
  assign mem_raddr = mem_read  ? line_addr : '0;
  assign mem_waddr = mem_write ? line_addr : '0;
  assign mem_wdata = mem_write ? wdata_sh  : '0;
  assign mem_wmask = mem_write ? wmask     : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      size_q     <= LSU_B;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wen_q   <= req_wen;
            size_q  <= lsu_size_e'(req_size);
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            // misaligned requests skip memory entirely
            if (misaligned) begin
              state_q    <= RESP;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q  <= ACCESS;
              resp_err <= 1'b0;
            end
          end
        end
        ACCESS: begin
          state_q    <= RESP;
          resp_err   <= 1'b0;
          resp_rdata <= wen_q ? '0 : rdata_ext;
        end
        RESP: begin
          if (resp_ready) begin
            state_q    <= IDLE;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: directed self-checking bench for npc_lsu.
// One task per scenario; expected values are hand-computed constants.
module tb_npc_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_raddr;
  logic        mem_read;
  logic [63:0] mem_rdata;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_write;

  int checks;
  int failures;
  int rd_cnt;
  int wr_cnt;

  npc_lsu #(.XLEN(64), .MASK_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_raddr    (mem_raddr),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_write    (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (rst_n) begin
      checks++;
      if (mem_read && mem_write) begin
        $display("FAIL strobe_excl read=%0b write=%0b required not both",
                 mem_read, mem_write);
        failures++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [1:0] size,
                       input logic uns, input logic [63:0] addr,
                       input logic [63:0] wdata);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0) begin
      $display("FAIL reset_flags got=%b required=0000",
               {resp_valid, resp_err, mem_read, mem_write});
      failures++;
    end
    checks++;
    if ({resp_rdata, mem_raddr, mem_waddr, mem_wdata} !== 256'd0
        || mem_wmask !== 8'h00) begin
      $display("FAIL reset_buses rdata=%h raddr=%h waddr=%h required 0",
               resp_rdata, mem_raddr, mem_waddr);
      failures++;
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL reset_ready got=%b required=1", req_ready);
      failures++;
    end
  endtask

  task automatic test_load_b_signed();
    int rd0;
    rd0 = rd_cnt;
    drive(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0);
    step();
    req_valid = 1'b0;
    mem_rdata = 64'h0000_0000_8000_0000;
    checks++;
    if (mem_read !== 1'b1 || mem_raddr !== 64'h8000_0000) begin
      $display("FAIL lb_strobe read=%b raddr=%h required 1/80000000",
               mem_read, mem_raddr);
      failures++;
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0
        || resp_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
      $display("FAIL lb_resp valid=%b err=%b rdata=%h required 1/0/ffffffffffffff80",
               resp_valid, resp_err, resp_rdata);
      failures++;
    end
    checks++;
    if (mem_read !== 1'b0 || rd_cnt - rd0 != 1) begin
      $display("FAIL lb_one_strobe read=%b pulses=%0d required 0/1",
               mem_read, rd_cnt - rd0);
      failures++;
    end
    step();
  endtask

  task automatic test_store_h();
    int wr0;
    wr0 = wr_cnt;
    drive(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_1234);
    step();
    req_valid = 1'b0;
    checks++;
    if (mem_write !== 1'b1 || mem_wmask !== 8'hC0
        || mem_wdata[63:48] !== 16'h1234 || mem_waddr !== 64'h8000_0000) begin
      $display("FAIL sh_strobe write=%b mask=%h wdata=%h waddr=%h required 1/c0/1234..../80000000",
               mem_write, mem_wmask, mem_wdata, mem_waddr);
      failures++;
    end
    checks++;
    if (mem_read !== 1'b0 || mem_raddr !== 64'd0) begin
      $display("FAIL sh_no_read read=%b raddr=%h required 0/0", mem_read, mem_raddr);
      failures++;
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'd0 || resp_err !== 1'b0
        || mem_write !== 1'b0 || mem_wmask !== 8'h00 || wr_cnt - wr0 != 1) begin
      $display("FAIL sh_resp valid=%b rdata=%h err=%b write=%b pulses=%0d required 1/0/0/0/1",
               resp_valid, resp_rdata, resp_err, mem_write, wr_cnt - wr0);
      failures++;
    end
    step();
  endtask

  task automatic test_misaligned();
    int rd0;
    int wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    resp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0);
    step();
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 64'd0) begin
      $display("FAIL mis_resp valid=%b err=%b rdata=%h required 1/1/0",
               resp_valid, resp_err, resp_rdata);
      failures++;
    end
    resp_ready = 1'b1;
    step();
    step();
    checks++;
    if (rd_cnt != rd0 || wr_cnt != wr0 || req_ready !== 1'b1) begin
      $display("FAIL mis_no_strobe reads=%0d writes=%0d ready=%b required 0/0/1",
               rd_cnt - rd0, wr_cnt - wr0, req_ready);
      failures++;
    end
  endtask

  task automatic test_backpressure();
    int rd0;
    rd0 = rd_cnt;
    resp_ready = 1'b0;
    mem_rdata  = 64'h1122_3344_5566_7788;
    drive(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0);
    step();
    step();
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122_3344_5566_7788
          || resp_err !== 1'b0 || req_ready !== 1'b0 || rd_cnt - rd0 != 1) begin
        $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h ready=%b pulses=%0d required 1/1122334455667788/0/1",
                 i, resp_valid, resp_rdata, req_ready, rd_cnt - rd0);
        failures++;
      end
      step();
    end
    resp_ready = 1'b1;
    step();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_read !== 1'b0) begin
      $display("FAIL bp_release valid=%b ready=%b read=%b required 0/1/0",
               resp_valid, req_ready, mem_read);
      failures++;
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (mem_read !== 1'b1 || mem_raddr !== 64'h8000_0008) begin
      $display("FAIL bp_accept read=%b raddr=%h required 1/80000008",
               mem_read, mem_raddr);
      failures++;
    end
    step();
    step();
  endtask

  task automatic test_lwu();
    drive(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0);
    step();
    req_valid = 1'b0;
    mem_rdata = 64'hF000_0001_DEAD_BEEF;
    step();
    checks++;
    if (resp_rdata !== 64'h0000_0000_F000_0001) begin
      $display("FAIL lwu_rdata got=%h required=00000000f0000001", resp_rdata);
      failures++;
    end
    step();
    drive(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0);
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (resp_rdata !== 64'hFFFF_FFFF_F000_0001) begin
      $display("FAIL lw_rdata got=%h required=fffffffff0000001", resp_rdata);
      failures++;
    end
    step();
    drive(1'b0, 2'd1, 1'b1, 64'h8000_0002, 64'd0);
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (resp_rdata !== 64'h0000_0000_0000_DEAD) begin
      $display("FAIL lhu_rdata got=%h required=000000000000dead", resp_rdata);
      failures++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    logic [5:0] exp_pat;
    exp_pat   = 6'b001001;
    mem_rdata = 64'd0;
    drive(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      seen[i] = mem_read;
    end
    req_valid = 1'b0;
    checks++;
    if (seen !== exp_pat) begin
      $display("FAIL b2b_pattern got=%b required=%b", seen, exp_pat);
      failures++;
    end
    step();
    step();
    step();
  endtask

  task automatic test_reset_mid_access();
    int wr0;
    drive(1'b1, 2'd3, 1'b0, 64'h8000_0020, 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    req_valid = 1'b0;
    checks++;
    if (mem_write !== 1'b1 || mem_wmask !== 8'hFF) begin
      $display("FAIL rst_pre_strobe write=%b mask=%h required 1/ff",
               mem_write, mem_wmask);
      failures++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    wr0 = wr_cnt;
    checks++;
    if (mem_write !== 1'b0 || mem_wmask !== 8'h00 || mem_waddr !== 64'd0
        || mem_wdata !== 64'd0 || resp_valid !== 1'b0) begin
      $display("FAIL rst_abort write=%b mask=%h waddr=%h valid=%b required all 0",
               mem_write, mem_wmask, mem_waddr, resp_valid);
      failures++;
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || wr_cnt != wr0) begin
        $display("FAIL rst_after cyc=%0d valid=%b ready=%b writes=%0d required 0/1/0",
                 i, resp_valid, req_ready, wr_cnt - wr0);
        failures++;
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rd_cnt       = 0;
    wr_cnt       = 0;
    req_valid    = 1'b0;
    req_wen      = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 64'd0;
    req_wdata    = 64'd0;
    resp_ready   = 1'b1;
    mem_rdata    = 64'd0;
    test_reset();
    test_load_b_signed();
    test_store_h();
    test_misaligned();
    test_backpressure();
    test_lwu();
    test_back_to_back();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
